fetch_issue_unit: RTL and testbench
===================================

# fetch_issue_unit

Front-end sequencer that supplies the control decoder with instructions. It holds the program counter and fetches 32-bit words from instruction memory over a request/acknowledge handshake. It splits each word into the op/inst/imm fields the decoder consumes, presents them with a valid/ready handshake, and applies the decoder's PC-redirect decision when the instruction is accepted.

## Interface
Parameters:
- PC_W, 16, program-counter and instruction-address width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  PC_W  fetch address (current PC)
- imem_ack  in  1  memory has returned data this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- op  out  2  instruction bits [31:30]
- inst  out  2  instruction bits [29:28]
- immin  out  1  instruction bit [27]
- instr  out  32  full latched instruction word, for operand fields
- pc_out  out  PC_W  address of the instruction currently presented
- valid  out  1  op/inst/immin/instr/pc_out hold a fetched instruction
- ready  in  1  decode stage accepts the presented instruction
- redirect  in  1  taken jump/PC write for the presented instruction
- redirect_pc  in  PC_W  target PC when redirect=1
- issue_count  out  16  number of accepted instructions, saturating

## Operation
- The FSM has 3 states: FETCH, WAIT, ISSUE.
- Reset:
  - state=FETCH, pc=RESET_PC, imem_req=0, valid=0, instr/op/inst/immin=0, pc_out=0, issue_count=0.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - If imem_ack=1 in the same cycle: latch imem_rdata into instr, pc_out<=pc, go to ISSUE.
  - Otherwise go to WAIT.
- WAIT:
  - imem_req=1, imem_addr=pc. Both are held steady until ack.
  - On imem_ack: latch the word, pc_out<=pc, go to ISSUE.
  - No timeout; the unit waits indefinitely.
- ISSUE:
  - valid=1, and all presented fields are stable while ready=0. imem_req=0.
  - On ready=1, the instruction is accepted:
    - pc <= redirect ? redirect_pc : pc+4.
    - issue_count increments.
    - Go to FETCH.
- op/inst/immin are combinational slices of the latched instr register. They never come directly from imem_rdata.
- redirect and redirect_pc are sampled only on the accepting edge (valid & ready). At any other time they are ignored.
- PC arithmetic is modulo 2^PC_W. pc+4 from 2^PC_W-4 wraps to 0. redirect_pc is used as given; no alignment check.
- issue_count saturates at 0xFFFF and never wraps.
- imem_ack received in ISSUE is a protocol violation and is ignored; the latched word is not overwritten.

## Timing
- imem_req is registered from state. It first asserts in the cycle after rst deasserts.
- Zero-wait memory (ack in the request cycle) takes FETCH→ISSUE in 1 cycle. valid is high the following cycle.
- Peak throughput is 1 instruction per 2 cycles. Each further memory wait cycle adds 1 cycle.
- valid deasserts on the cycle after acceptance. The next imem_req asserts in that same cycle, with imem_addr equal to the updated pc.
- Reset asserted in any state (including WAIT with an outstanding request) returns all outputs to their reset values at the next edge. A late ack after reset is treated like any ack in FETCH: it is accepted only if it arrives while imem_req=1.
- Simultaneous ready=1 and redirect=1: the redirect wins over pc+4. The accepted instruction is still counted.

## Test plan
- Reset release, RESET_PC=0x0100, memory acks the same cycle with 0xA8000000 → imem_addr=0x0100; next cycle valid=1, op=2'b10, inst=2'b10, immin=1, pc_out=0x0100.
- Sequential stream with ready tied high and 3 zero-wait words → addresses 0x0100, 0x0104, 0x0108 on consecutive requests; issue_count=3; valid pulses every 2nd cycle.
- Memory delays ack by 4 cycles → imem_req and imem_addr are held for 5 cycles; valid rises 1 cycle after ack; fields match rdata.
- Hold ready=0 for 6 cycles in ISSUE, then raise ready with redirect=1, redirect_pc=0x0040 → fields stay stable throughout, no imem_req during the hold, next fetch address=0x0040.
- PC_W=16, pc=0xFFFC, accepted without redirect → next imem_addr=0x0000.
- Assert rst during WAIT, then ack arrives after rst drops → all outputs return to reset values and the next fetch is at RESET_PC. Preload issue_count near 0xFFFF via 65535+ accepts → count holds at 0xFFFF.

Source files
------------

// File: rtl/fetch_issue_unit.sv
// Instruction fetch/issue sequencer: fetches 32-bit words over a req/ack port,
// presents the decoded fields to the decode stage and applies its PC redirect.
module fetch_issue_unit #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [1:0]      op,
  output logic [1:0]      inst,
  output logic            immin,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] pc_out,
  output logic            valid,
  input  logic            ready,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     issue_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;
  logic [31:0]     instr_q, instr_d;
  logic            req_q, req_d;
  logic [15:0]     issue_count_q, issue_count_d;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    pc_d          = pc_q;
    pc_out_d      = pc_out_q;
    instr_d       = instr_q;
    issue_count_d = issue_count_q;

    unique case (state_q)
      FETCH, WAIT: begin
        // An ack only counts while a request is actually on the port; the
        // first FETCH cycle after reset has req low and simply raises it.
        if (req_q && imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          state_d  = ISSUE;
        end else if (req_q) begin
          state_d = WAIT;
        end
      end
      ISSUE: begin
        if (ready) begin
          pc_d = redirect ? redirect_pc : pc_q + PC_W'(4);
          if (issue_count_q != 16'hFFFF) begin
            issue_count_d = issue_count_q + 16'd1;
          end
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // Request is registered: it is high in exactly the cycles spent in FETCH/WAIT.
    req_d = (state_d != ISSUE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      pc_out_q      <= '0;
      instr_q       <= '0;
      req_q         <= 1'b0;
      issue_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_out_q      <= pc_out_d;
      instr_q       <= instr_d;
      req_q         <= req_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign op          = instr_q[31:30];
  assign inst        = instr_q[29:28];
  assign immin       = instr_q[27];
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign valid       = (state_q == ISSUE);
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Self-checking bench for fetch_issue_unit: transaction-level model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fetch_issue_unit;

  localparam int          PC_W     = 16;
  localparam logic [15:0] RESET_PC = 16'h0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  op;
  logic [1:0]  inst;
  logic        immin;
  logic [31:0] instr;
  logic [15:0] pc_out;
  logic        valid;
  logic        ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] issue_count;

  fetch_issue_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .op         (op),
    .inst       (inst),
    .immin      (immin),
    .instr      (instr),
    .pc_out     (pc_out),
    .valid      (valid),
    .ready      (ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == RESET_PC) return 32'hA800_0000;
    return {a[7:0], a[15:8], ~a};
  endfunction

  // Transaction-level model: an instruction is either being requested or presented.
  logic        m_known = 1'b0;
  logic        m_req, m_valid;
  logic [15:0] m_pc, m_pcout, m_cnt;
  logic [31:0] m_word;
  logic        preload = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_known <= 1'b1;
      m_req   <= 1'b0;
      m_valid <= 1'b0;
      m_pc    <= RESET_PC;
      m_pcout <= 16'h0;
      m_word  <= 32'h0;
      m_cnt   <= 16'h0;
    end else if (m_known) begin
      if (m_valid) begin
        if (ready) begin
          m_pc    <= redirect ? redirect_pc : m_pc + 16'd4;
          m_cnt   <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
          m_valid <= 1'b0;
          m_req   <= 1'b1;
        end
      end else if (m_req && imem_ack) begin
        m_word  <= imem_rdata;
        m_pcout <= m_pc;
        m_valid <= 1'b1;
        m_req   <= 1'b0;
      end else begin
        m_req <= 1'b1;
      end
    end
    if (preload) m_cnt <= 16'hFFFC;
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("cyc_imem_req", 32'(imem_req), 32'(m_req));
      check("cyc_imem_addr", 32'(imem_addr), 32'(m_pc));
      check("cyc_valid", 32'(valid), 32'(m_valid));
      check("cyc_issue_count", 32'(issue_count), 32'(m_cnt));
      check("cyc_instr", instr, m_word);
      check("cyc_op", 32'(op), 32'(m_word[31:30]));
      check("cyc_inst", 32'(inst), 32'(m_word[29:28]));
      check("cyc_immin", 32'(immin), 32'(m_word[27]));
      check("cyc_pc_out", 32'(pc_out), 32'(m_pcout));
    end
  end

  // Memory responder knobs, owned by the stimulus process.
  int   ack_delay = 0;
  int   wait_cnt  = 0;
  logic stray     = 1'b0;

  task automatic step();
    @(negedge clk);
    if (stray && valid) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'h5555_5555;
    end else if (imem_req && wait_cnt >= ack_delay) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      wait_cnt   = 0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hCAFE_F00D;
      wait_cnt   = imem_req ? wait_cnt + 1 : 0;
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid && n < 50) begin
      step();
      n++;
    end
    check(name, 32'(valid), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    int n;
    int guard;

    rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (3) step();

    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", 32'(issue_count), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'h0100);
    check("rst_instr", instr, 32'h0);
    check("rst_pc_out", 32'(pc_out), 32'h0);

    // First fetch with zero-wait memory.
    rst = 1'b0;
    step();
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_addr", 32'(imem_addr), 32'h0100);
    step();
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_op", 32'(op), 32'd2);
    check("t1_inst", 32'(inst), 32'd2);
    check("t1_immin", 32'(immin), 32'd1);
    check("t1_pc_out", 32'(pc_out), 32'h0100);

    // Sequential stream, ready tied high.
    ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      step();
      check("t2_gap_valid", 32'(valid), 32'd0);
      check("t2_req", 32'(imem_req), 32'd1);
      check("t2_addr", 32'(imem_addr), 32'(16'h0100 + 16'(4 * k)));
      step();
      check("t2_valid", 32'(valid), 32'd1);
      check("t2_pc_out", 32'(pc_out), 32'(16'h0100 + 16'(4 * k)));
    end
    step();
    check("t2_count", 32'(issue_count), 32'd3);
    check("t2_next_addr", 32'(imem_addr), 32'h010C);
    ready = 1'b0;
    step();
    check("t2_valid_10c", 32'(valid), 32'd1);

    // Memory delays ack: request held 5 cycles.
    ack_delay = 4;
    ready = 1'b1;
    step();
    ready = 1'b0;
    n = 0;
    guard = 0;
    while (!valid && guard < 20) begin
      if (imem_req && imem_addr == 16'h0110) n++;
      step();
      guard++;
    end
    check("t3_req_cycles", 32'(n), 32'd5);
    check("t3_valid", 32'(valid), 32'd1);
    check("t3_instr", instr, mem_word(16'h0110));
    check("t3_pc_out", 32'(pc_out), 32'h0110);
    ack_delay = 0;

    // Hold in ISSUE; stray acks and redirect without ready are ignored.
    w = mem_word(16'h0110);
    stray = 1'b1; redirect = 1'b1; redirect_pc = 16'h7777;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t4_valid", 32'(valid), 32'd1);
      check("t4_req", 32'(imem_req), 32'd0);
      check("t4_instr", instr, w);
      check("t4_op", 32'(op), 32'(w[31:30]));
      check("t4_pc_out", 32'(pc_out), 32'h0110);
    end
    stray = 1'b0;
    ready = 1'b1; redirect_pc = 16'h0040;
    step();
    check("t4_redirect_addr", 32'(imem_addr), 32'h0040);
    check("t4_count", 32'(issue_count), 32'd5);
    ready = 1'b0; redirect = 1'b0; redirect_pc = 16'hBEEF;
    step();
    check("t4_valid_40", 32'(valid), 32'd1);
    check("t4_pc_out_40", 32'(pc_out), 32'h0040);

    // PC wrap from 0xFFFC.
    ready = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFC;
    step();
    check("t5_addr_fffc", 32'(imem_addr), 32'hFFFC);
    redirect = 1'b0; redirect_pc = 16'h1234;
    step();
    check("t5_pc_out_fffc", 32'(pc_out), 32'hFFFC);
    step();
    check("t5_wrap_addr", 32'(imem_addr), 32'h0000);
    check("t5_count", 32'(issue_count), 32'd7);
    ready = 1'b0;
    wait_valid("t5_valid_timeout");

    // Reset during WAIT; a late ack while req is low must be ignored.
    ack_delay = 100;
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    check("t6_wait_req", 32'(imem_req), 32'd1);
    check("t6_wait_addr", 32'(imem_addr), 32'h0004);
    rst = 1'b1;
    step();
    check("t6_rst_req", 32'(imem_req), 32'd0);
    check("t6_rst_valid", 32'(valid), 32'd0);
    check("t6_rst_count", 32'(issue_count), 32'd0);
    check("t6_rst_addr", 32'(imem_addr), 32'h0100);
    check("t6_rst_instr", instr, 32'h0);
    rst = 1'b0; ack_delay = 0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    check("t6_late_ack_valid", 32'(valid), 32'd0);
    check("t6_late_ack_instr", instr, 32'h0);
    check("t6_refetch_addr", 32'(imem_addr), 32'h0100);
    step();
    check("t6_valid", 32'(valid), 32'd1);
    check("t6_instr", instr, 32'hA800_0000);

    // Saturation: the counter is preloaded near its ceiling instead of
    // running 65535 accepts.
    force dut.issue_count_d = 16'hFFFC;
    preload = 1'b1;
    step();
    release dut.issue_count_d;
    preload = 1'b0;
    check("t7_preload", 32'(issue_count), 32'hFFFC);
    ready = 1'b1;
    repeat (10) step();
    check("t7_saturated", 32'(issue_count), 32'hFFFF);
    ready = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
